// File: rtl/ps2_kbd_decoder_fifo.sv
// PS/2 scan-code-set-2 decoder with typematic repeat filter and first-word
// fall-through event FIFO. E0/F0 prefixes and the E1 Pause sequence are folded
// into single key events. Keyboard controller responses go to status_o.
module ps2_kbd_decoder_fifo #(
  parameter int unsigned FIFO_DEPTH      = 16,
  parameter int unsigned TIMEOUT_CYCLES  = 1_000_000,
  parameter bit          SUPPRESS_REPEAT = 1'b1,
  localparam int unsigned CntW           = $clog2(FIFO_DEPTH) + 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [7:0]      data_i,
  input  logic            valid_i,
  output logic [7:0]      event_code_o,
  output logic            event_break_o,
  output logic            event_extended_o,
  output logic            event_pause_o,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [CntW-1:0] count_o,
  output logic            overflow_o,
  input  logic            clear_overflow_i,
  output logic [7:0]      status_o,
  output logic            status_valid_o
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);
  localparam logic [CntW-1:0] CntFull = CntW'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StPrefix, StPause} state_e;

  typedef struct packed {
    logic       pause;
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } event_t;

  function automatic logic is_response(input logic [7:0] b);
    case (b)
      8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'hFC, 8'h00, 8'hFF: is_response = 1'b1;
      default:                                           is_response = 1'b0;
    endcase
  endfunction

  // Decoder state
  state_e          state_q, state_d;
  logic            ext_q, ext_d;
  logic            brk_q, brk_d;
  logic [2:0]      pcnt_q, pcnt_d;
  logic [TmoW-1:0] tmo_q, tmo_d;

  // Registered decoder output (one event or one status byte per cycle)
  logic            evt_valid_q, evt_valid_d;
  event_t          evt_q, evt_d;
  logic [7:0]      status_q, status_d;
  logic            status_valid_q, status_valid_d;

  // Repeat filter
  logic            last_valid_q, last_valid_d;
  logic            last_ext_q, last_ext_d;
  logic [7:0]      last_code_q, last_code_d;
  logic            push_req;

  // FIFO
  event_t          mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [CntW-1:0] count_q, count_d;
  logic            overflow_q, overflow_d;
  logic            empty, full, push, pop;

  // Decoder next-state: prefix folding, Pause counting, response capture, timeout
  always_comb begin
    state_d        = state_q;
    ext_d          = ext_q;
    brk_d          = brk_q;
    pcnt_d         = pcnt_q;
    tmo_d          = '0;
    evt_valid_d    = 1'b0;
    evt_d          = '0;
    status_d       = status_q;
    status_valid_d = 1'b0;
    unique case (state_q)
      StIdle, StPrefix: begin
        if (valid_i) begin
          if (data_i == 8'hE0) begin
            ext_d   = 1'b1;
            state_d = StPrefix;
          end else if (data_i == 8'hF0) begin
            brk_d   = 1'b1;
            state_d = StPrefix;
          end else if (data_i == 8'hE1) begin
            ext_d   = 1'b0;
            brk_d   = 1'b0;
            pcnt_d  = 3'd7;
            state_d = StPause;
          end else if (is_response(data_i)) begin
            status_d       = data_i;
            status_valid_d = 1'b1;
            ext_d          = 1'b0;
            brk_d          = 1'b0;
            state_d        = StIdle;
          end else begin
            evt_valid_d = 1'b1;
            evt_d       = '{pause: 1'b0, ext: ext_q, brk: brk_q, code: data_i};
            ext_d       = 1'b0;
            brk_d       = 1'b0;
            state_d     = StIdle;
          end
        end else if (state_q == StPrefix) begin
          if (tmo_q == TmoLast) begin
            ext_d   = 1'b0;
            brk_d   = 1'b0;
            state_d = StIdle;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
      end
      StPause: begin
        if (valid_i) begin
          // Bytes of the Pause sequence are counted, not inspected
          if (pcnt_q == 3'd1) begin
            pcnt_d      = 3'd0;
            evt_valid_d = 1'b1;
            evt_d       = '{pause: 1'b1, ext: 1'b0, brk: 1'b0, code: 8'h00};
            state_d     = StIdle;
          end else begin
            pcnt_d = pcnt_q - 3'd1;
          end
        end else if (tmo_q == TmoLast) begin
          ext_d   = 1'b0;
          brk_d   = 1'b0;
          state_d = StIdle;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Repeat filter: drop makes that repeat the last held-down key
  always_comb begin
    push_req     = evt_valid_q;
    last_valid_d = last_valid_q;
    last_ext_d   = last_ext_q;
    last_code_d  = last_code_q;
    if (SUPPRESS_REPEAT && evt_valid_q && !evt_q.pause) begin
      if (!evt_q.brk) begin
        if (last_valid_q && last_ext_q == evt_q.ext && last_code_q == evt_q.code) begin
          push_req = 1'b0;
        end else begin
          last_valid_d = 1'b1;
          last_ext_d   = evt_q.ext;
          last_code_d  = evt_q.code;
        end
      end else if (last_valid_q && last_ext_q == evt_q.ext && last_code_q == evt_q.code) begin
        last_valid_d = 1'b0;
      end
    end
  end

  // FIFO control; a full FIFO still accepts a push on a pop edge
  always_comb begin
    empty      = (count_q == '0);
    full       = (count_q == CntFull);
    pop        = !empty && ready_i;
    push       = push_req && (!full || pop);
    count_d    = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
    overflow_d = overflow_q;
    if (push_req && !push) begin
      overflow_d = 1'b1;
    end else if (clear_overflow_i) begin
      overflow_d = 1'b0;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q        <= StIdle;
      ext_q          <= 1'b0;
      brk_q          <= 1'b0;
      pcnt_q         <= '0;
      tmo_q          <= '0;
      evt_valid_q    <= 1'b0;
      evt_q          <= '0;
      status_q       <= '0;
      status_valid_q <= 1'b0;
      last_valid_q   <= 1'b0;
      last_ext_q     <= 1'b0;
      last_code_q    <= '0;
      wptr_q         <= '0;
      rptr_q         <= '0;
      count_q        <= '0;
      overflow_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      ext_q          <= ext_d;
      brk_q          <= brk_d;
      pcnt_q         <= pcnt_d;
      tmo_q          <= tmo_d;
      evt_valid_q    <= evt_valid_d;
      evt_q          <= evt_d;
      status_q       <= status_d;
      status_valid_q <= status_valid_d;
      last_valid_q   <= last_valid_d;
      last_ext_q     <= last_ext_d;
      last_code_q    <= last_code_d;
      count_q        <= count_d;
      overflow_q     <= overflow_d;
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  // FIFO storage; contents are don't-care while count is zero
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= evt_q;
  end

  // Head fields are forced to zero when empty so reset shows all-zero outputs
  always_comb begin
    valid_o          = !empty;
    event_code_o     = valid_o ? mem_q[rptr_q].code  : 8'h00;
    event_break_o    = valid_o ? mem_q[rptr_q].brk   : 1'b0;
    event_extended_o = valid_o ? mem_q[rptr_q].ext   : 1'b0;
    event_pause_o    = valid_o ? mem_q[rptr_q].pause : 1'b0;
    count_o          = count_q;
    overflow_o       = overflow_q;
    status_o         = status_q;
    status_valid_o   = status_valid_q;
  end

endmodule

// File: tb/tb_ps2_kbd_decoder_fifo.sv
// Directed bench: dut_a (depth 4, timeout 8, repeat suppression on) and
// dut_b (depth 16, timeout 8, repeat suppression off) share the byte stream.
module tb_ps2_kbd_decoder_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       ready_b;
  logic       clr;

  logic [7:0] code_a, status_a, code_b, status_b;
  logic       brk_a, ext_a, pause_a, valid_a, ovf_a, sv_a;
  logic       brk_b, ext_b, pause_b, valid_b, ovf_b, sv_b;
  logic [2:0] count_a;
  logic [4:0] count_b;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  ps2_kbd_decoder_fifo #(
    .FIFO_DEPTH     (4),
    .TIMEOUT_CYCLES (8),
    .SUPPRESS_REPEAT(1'b1)
  ) dut_a (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .data_i          (data),
    .valid_i         (valid),
    .event_code_o    (code_a),
    .event_break_o   (brk_a),
    .event_extended_o(ext_a),
    .event_pause_o   (pause_a),
    .valid_o         (valid_a),
    .ready_i         (ready),
    .count_o         (count_a),
    .overflow_o      (ovf_a),
    .clear_overflow_i(clr),
    .status_o        (status_a),
    .status_valid_o  (sv_a)
  );

  ps2_kbd_decoder_fifo #(
    .FIFO_DEPTH     (16),
    .TIMEOUT_CYCLES (8),
    .SUPPRESS_REPEAT(1'b0)
  ) dut_b (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .data_i          (data),
    .valid_i         (valid),
    .event_code_o    (code_b),
    .event_break_o   (brk_b),
    .event_extended_o(ext_b),
    .event_pause_o   (pause_b),
    .valid_o         (valid_b),
    .ready_i         (ready_b),
    .count_o         (count_b),
    .overflow_o      (ovf_b),
    .clear_overflow_i(clr),
    .status_o        (status_b),
    .status_valid_o  (sv_b)
  );

  // Event packed as {pause, ext, brk, code}
  function automatic logic [10:0] ev(input logic p, input logic e, input logic b,
                                     input logic [7:0] c);
    ev = {p, e, b, c};
  endfunction

  // Drive one byte strobe; called and returns on a falling edge
  task automatic drive(input logic [7:0] b);
    data  = b;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
  endtask

  // Wait (bounded) for a head event on dut_a, capture it, pop it
  task automatic get_event(output bit ok, output logic [10:0] e);
    ok = 1'b0;
    e  = '0;
    for (int i = 0; i < 10; i++) begin
      if (valid_a) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) begin
      e     = {pause_a, ext_a, brk_a, code_a};
      ready = 1'b1;
      @(negedge clk);
      ready = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; valid = 1'b0; data = 8'h00; ready = 1'b0; ready_b = 1'b1; clr = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({count_a, valid_a, ovf_a, sv_a} !== 6'b0)
      $display("FAIL reset_ctrl: got count=%0d valid=%b ovf=%b sv=%b want all 0",
               count_a, valid_a, ovf_a, sv_a);
    else passes++;
    checks++;
    if ({status_a, code_a, brk_a, ext_a, pause_a} !== 19'b0)
      $display("FAIL reset_fields: got status=%h code=%h b=%b e=%b p=%b want all 0",
               status_a, code_a, brk_a, ext_a, pause_a);
    else passes++;
  endtask

  task automatic test_basic;
    bit ok;
    logic [10:0] got;
    logic [10:0] exp [4];
    exp[0] = ev(0, 0, 0, 8'h1C);
    exp[1] = ev(0, 0, 1, 8'h1C);
    exp[2] = ev(0, 1, 0, 8'h75);
    exp[3] = ev(0, 1, 1, 8'h75);
    drive(8'h1C);
    checks++;
    if (valid_a !== 1'b0) $display("FAIL latency_n1: got valid=%b want 0", valid_a);
    else passes++;
    @(negedge clk);
    checks++;
    if (valid_a !== 1'b1 || code_a !== 8'h1C)
      $display("FAIL latency_n2: got valid=%b code=%h want 1 1c", valid_a, code_a);
    else passes++;
    drive(8'hF0); drive(8'h1C); drive(8'hE0); drive(8'h75);
    drive(8'hE0); drive(8'hF0); drive(8'h75);
    repeat (3) @(negedge clk);
    checks++;
    if (count_a !== 3'd4 || ovf_a !== 1'b0)
      $display("FAIL basic_count: got count=%0d ovf=%b want 4 0", count_a, ovf_a);
    else passes++;
    for (int i = 0; i < 4; i++) begin
      get_event(ok, got);
      checks++;
      if (!ok || got !== exp[i])
        $display("FAIL basic_event%0d: got ok=%b ev=%h want %h", i, ok, got, exp[i]);
      else passes++;
    end
  endtask

  task automatic test_pause;
    bit ok;
    logic [10:0] got;
    drive(8'hE1); drive(8'h14); drive(8'h77); drive(8'hE1);
    drive(8'hF0); drive(8'h14); drive(8'hF0); drive(8'h77);
    repeat (3) @(negedge clk);
    checks++;
    if (count_a !== 3'd1) $display("FAIL pause_count: got %0d want 1", count_a);
    else passes++;
    get_event(ok, got);
    checks++;
    if (!ok || got !== ev(1, 0, 0, 8'h00))
      $display("FAIL pause_event: got ok=%b ev=%h want %h", ok, got, ev(1, 0, 0, 8'h00));
    else passes++;
    checks++;
    if (valid_a !== 1'b0) $display("FAIL pause_empty: got valid=%b want 0", valid_a);
    else passes++;
  endtask

  task automatic test_repeat;
    bit ok;
    logic [10:0] got;
    logic [10:0] exp [3];
    exp[0] = ev(0, 0, 0, 8'h1C);
    exp[1] = ev(0, 0, 1, 8'h1C);
    exp[2] = ev(0, 0, 0, 8'h1C);
    ready_b = 1'b0;
    drive(8'h1C); drive(8'h1C); drive(8'h1C); drive(8'hF0); drive(8'h1C); drive(8'h1C);
    repeat (3) @(negedge clk);
    checks++;
    if (count_a !== 3'd3) $display("FAIL repeat_count_on: got %0d want 3", count_a);
    else passes++;
    checks++;
    if (count_b !== 5'd5) $display("FAIL repeat_count_off: got %0d want 5", count_b);
    else passes++;
    ready_b = 1'b1;
    for (int i = 0; i < 3; i++) begin
      get_event(ok, got);
      checks++;
      if (!ok || got !== exp[i])
        $display("FAIL repeat_event%0d: got ok=%b ev=%h want %h", i, ok, got, exp[i]);
      else passes++;
    end
    // Release the key so later 1C makes are not treated as repeats
    drive(8'hF0); drive(8'h1C);
    get_event(ok, got);
    checks++;
    if (!ok || got !== ev(0, 0, 1, 8'h1C))
      $display("FAIL repeat_release: got ok=%b ev=%h want %h", ok, got, ev(0, 0, 1, 8'h1C));
    else passes++;
  endtask

  task automatic test_status;
    bit ok;
    logic [10:0] got;
    drive(8'hFA);
    checks++;
    if (sv_a !== 1'b1 || status_a !== 8'hFA)
      $display("FAIL status_fa: got sv=%b status=%h want 1 fa", sv_a, status_a);
    else passes++;
    @(negedge clk);
    checks++;
    if (sv_a !== 1'b0) $display("FAIL status_pulse: got sv=%b want 0", sv_a);
    else passes++;
    drive(8'hE0); drive(8'hAA);
    checks++;
    if (sv_a !== 1'b1 || status_a !== 8'hAA)
      $display("FAIL status_aa: got sv=%b status=%h want 1 aa", sv_a, status_a);
    else passes++;
    @(negedge clk);
    checks++;
    if (count_a !== 3'd0) $display("FAIL status_noevent: got count=%0d want 0", count_a);
    else passes++;
    drive(8'h1C);
    get_event(ok, got);
    checks++;
    if (!ok || got !== ev(0, 0, 0, 8'h1C))
      $display("FAIL status_extclr: got ok=%b ev=%h want %h", ok, got, ev(0, 0, 0, 8'h1C));
    else passes++;
  endtask

  task automatic test_timeout;
    bit ok;
    logic [10:0] got;
    drive(8'hE0);
    repeat (8) @(negedge clk);
    drive(8'h2B);
    get_event(ok, got);
    checks++;
    if (!ok || got !== ev(0, 0, 0, 8'h2B))
      $display("FAIL timeout_8: got ok=%b ev=%h want %h", ok, got, ev(0, 0, 0, 8'h2B));
    else passes++;
    drive(8'hE0);
    repeat (7) @(negedge clk);
    drive(8'h2B);
    get_event(ok, got);
    checks++;
    if (!ok || got !== ev(0, 1, 0, 8'h2B))
      $display("FAIL timeout_7: got ok=%b ev=%h want %h", ok, got, ev(0, 1, 0, 8'h2B));
    else passes++;
  endtask

  task automatic test_overflow;
    bit ok;
    logic [10:0] got;
    logic [7:0] exp [4];
    exp[0] = 8'h12; exp[1] = 8'h13; exp[2] = 8'h14; exp[3] = 8'h16;
    drive(8'h11); drive(8'h12); drive(8'h13); drive(8'h14); drive(8'h15);
    repeat (3) @(negedge clk);
    checks++;
    if (count_a !== 3'd4 || ovf_a !== 1'b1 || code_a !== 8'h11)
      $display("FAIL ovf_full: got count=%0d ovf=%b head=%h want 4 1 11",
               count_a, ovf_a, code_a);
    else passes++;
    // Sixth make reaches the FIFO on the same edge as a pop
    data  = 8'h16;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    checks++;
    if (count_a !== 3'd4 || code_a !== 8'h12)
      $display("FAIL ovf_pushpop: got count=%0d head=%h want 4 12", count_a, code_a);
    else passes++;
    for (int i = 0; i < 4; i++) begin
      get_event(ok, got);
      checks++;
      if (!ok || got !== ev(0, 0, 0, exp[i]))
        $display("FAIL ovf_drain%0d: got ok=%b ev=%h want %h", i, ok, got, ev(0, 0, 0, exp[i]));
      else passes++;
    end
    checks++;
    if (ovf_a !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", ovf_a);
    else passes++;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    checks++;
    if (ovf_a !== 1'b0) $display("FAIL ovf_clear: got %b want 0", ovf_a);
    else passes++;
  endtask

  task automatic test_mid_reset;
    bit ok;
    logic [10:0] got;
    drive(8'h21); drive(8'hE0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (count_a !== 3'd0 || valid_a !== 1'b0)
      $display("FAIL midreset_flush: got count=%0d valid=%b want 0 0", count_a, valid_a);
    else passes++;
    drive(8'h1C);
    get_event(ok, got);
    checks++;
    if (!ok || got !== ev(0, 0, 0, 8'h1C))
      $display("FAIL midreset_ext: got ok=%b ev=%h want %h", ok, got, ev(0, 0, 0, 8'h1C));
    else passes++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pause();
    test_repeat();
    test_status();
    test_timeout();
    test_overflow();
    test_mid_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200000");
    $fatal(1);
  end

endmodule
